// File: rtl/csi_pkt_pkg.sv
// Shared constants, header field offsets and state type for the CSI-2 packet controller.
package csi_pkt_pkg;

  localparam int unsigned DAT_W   = 32;
  localparam int unsigned DT_W    = 6;
  localparam int unsigned VC_W    = 2;
  localparam int unsigned WC_W    = 16;
  localparam int unsigned ECC_W   = 6;
  localparam int unsigned REM_W   = 17;
  localparam int unsigned BE_W    = 4;

  localparam int unsigned DT_LSB  = 0;
  localparam int unsigned VC_LSB  = 6;
  localparam int unsigned WC_LSB  = 8;
  localparam int unsigned ECC_LSB = 24;

  localparam logic [DT_W-1:0] DT_FS        = 6'h00;
  localparam logic [DT_W-1:0] DT_FE        = 6'h01;
  localparam logic [DT_W-1:0] DT_LS        = 6'h02;
  localparam logic [DT_W-1:0] DT_LE        = 6'h03;
  localparam logic [DT_W-1:0] DT_SHORT_MAX = 6'h0F;

  typedef enum logic {
    IDLE,
    PAYLOAD
  } state_t;

  // Byte enables for a word carrying min(pay, 4) payload bytes; only valid for pay > 0.
  function automatic logic [BE_W-1:0] be_from_pay(input logic signed [REM_W:0] pay);
    logic [BE_W-1:0] be;
    if (pay >= 18'sd4) be = 4'hF;
    else begin
      unique case (pay[1:0])
        2'd3:    be = 4'h7;
        2'd2:    be = 4'h3;
        default: be = 4'h1;
      endcase
    end
    return be;
  endfunction

endpackage

// File: rtl/csi_ecc_calc.sv
// CSI-2 packet header ECC generator: 6 parity bits over the 24-bit header.
module csi_ecc_calc (
  input  logic [23:0] data,
  output logic [5:0]  ecc
);

  localparam logic [23:0] M0 = 24'hF12CB7;
  localparam logic [23:0] M1 = 24'hF2555B;
  localparam logic [23:0] M2 = 24'h749A6D;
  localparam logic [23:0] M3 = 24'hB8E38E;
  localparam logic [23:0] M4 = 24'hDF03F0;
  localparam logic [23:0] M5 = 24'hEFFC00;

  assign ecc = {^(data & M5), ^(data & M4), ^(data & M3),
                ^(data & M2), ^(data & M1), ^(data & M0)};

endmodule

// File: rtl/csi_pkt_ctrl.sv
// CSI-2 packet controller: header parse, payload/CRC sequencing, sync events, aligner resync.
// Optional header ECC check is built when CSI_PKT_ECC_CHECK_EN is defined.
module csi_pkt_ctrl
  import csi_pkt_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [DAT_W-1:0] merging_dat,
  input  logic             merging_valid,
  input  logic             pkt_sof,
  output logic             frame_start,
  output logic             frame_end,
  output logic             line_start,
  output logic             line_end,
  output logic [VC_W-1:0]  vc_o,
  output logic [DT_W-1:0]  dt_o,
  output logic [WC_W-1:0]  wc_o,
  output logic [DAT_W-1:0] pld_data,
  output logic [BE_W-1:0]  pld_be,
  output logic             pld_valid,
  output logic             pld_last,
  output logic             lane_resync,
  output logic             err_ecc,
  output logic             err_timeout,
  output logic             err_trunc,
  output logic             busy
);

  localparam int unsigned TW = $clog2(TIMEOUT);

  state_t           state_q, state_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [TW-1:0]    idle_q, idle_d;

  logic             fs_d, fe_d, ls_d, le_d, rs_d, ecc_d, to_d, tr_d, pv_d, pl_d;
  logic [BE_W-1:0]  be_d;
  logic [DAT_W-1:0] data_d;
  logic [VC_W-1:0]  vc_d;
  logic [DT_W-1:0]  dt_d;
  logic [WC_W-1:0]  wc_d;
  logic             take_hdr;
  logic             ecc_ok;
  logic signed [REM_W:0] pay;

  wire [DT_W-1:0] hdr_dt = merging_dat[DT_LSB +: DT_W];
  wire [VC_W-1:0] hdr_vc = merging_dat[VC_LSB +: VC_W];
  wire [WC_W-1:0] hdr_wc = merging_dat[WC_LSB +: WC_W];

`ifdef CSI_PKT_ECC_CHECK_EN
  logic [ECC_W-1:0] ecc_calc;
  logic             unused_dat;
  csi_ecc_calc u_ecc (
    .data (merging_dat[ECC_LSB-1:0]),
    .ecc  (ecc_calc)
  );
  assign ecc_ok     = (ecc_calc == merging_dat[ECC_LSB +: ECC_W]);
  assign unused_dat = ^merging_dat[DAT_W-1:ECC_LSB+ECC_W];
`else
  logic unused_dat;
  assign ecc_ok     = 1'b1;
  assign unused_dat = ^merging_dat[DAT_W-1:ECC_LSB];
`endif

  // Payload bytes still owed; the trailing 2 bytes of rem are CRC.
  assign pay = $signed({1'b0, rem_q}) - 18'sd2;

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    idle_d   = idle_q;
    fs_d     = 1'b0;
    fe_d     = 1'b0;
    ls_d     = 1'b0;
    le_d     = 1'b0;
    rs_d     = 1'b0;
    ecc_d    = 1'b0;
    to_d     = 1'b0;
    tr_d     = 1'b0;
    pv_d     = 1'b0;
    pl_d     = 1'b0;
    be_d     = pld_be;
    data_d   = pld_data;
    vc_d     = vc_o;
    dt_d     = dt_o;
    wc_d     = wc_o;
    take_hdr = 1'b0;

    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: take_hdr = merging_valid & pkt_sof;
        PAYLOAD: begin
          if (merging_valid && pkt_sof) begin
            tr_d     = 1'b1;
            state_d  = IDLE;
            take_hdr = 1'b1;
          end else if (merging_valid) begin
            idle_d = '0;
            if (pay > 18'sd0) begin
              pv_d   = 1'b1;
              be_d   = be_from_pay(pay);
              pl_d   = (pay <= 18'sd4);
              data_d = merging_dat;
            end
            rem_d = rem_q - 17'd4;
            if (rem_q <= 17'd4) begin
              rs_d    = 1'b1;
              state_d = IDLE;
            end
          end else if (idle_q == TW'(TIMEOUT - 1)) begin
            to_d    = 1'b1;
            rs_d    = 1'b1;
            state_d = IDLE;
          end else begin
            idle_d = idle_q + TW'(1);
          end
        end
        default: state_d = IDLE;
      endcase

      // A header rejected by ECC leaves the latched fields untouched.
      if (take_hdr) begin
        if (!ecc_ok) begin
          ecc_d = 1'b1;
          rs_d  = 1'b1;
        end else begin
          vc_d = hdr_vc;
          dt_d = hdr_dt;
          wc_d = hdr_wc;
          if (hdr_dt <= DT_SHORT_MAX) begin
            rs_d = 1'b1;
            fs_d = (hdr_dt == DT_FS);
            fe_d = (hdr_dt == DT_FE);
            ls_d = (hdr_dt == DT_LS);
            le_d = (hdr_dt == DT_LE);
          end else begin
            rem_d   = {1'b0, hdr_wc} + 17'd2;
            idle_d  = '0;
            state_d = PAYLOAD;
          end
        end
      end
    end

    if (state_d == IDLE) idle_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      idle_q      <= '0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      line_start  <= 1'b0;
      line_end    <= 1'b0;
      lane_resync <= 1'b0;
      err_ecc     <= 1'b0;
      err_timeout <= 1'b0;
      err_trunc   <= 1'b0;
      pld_valid   <= 1'b0;
      pld_last    <= 1'b0;
      pld_be      <= '0;
      pld_data    <= '0;
      vc_o        <= '0;
      dt_o        <= '0;
      wc_o        <= '0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      idle_q      <= idle_d;
      frame_start <= fs_d;
      frame_end   <= fe_d;
      line_start  <= ls_d;
      line_end    <= le_d;
      lane_resync <= rs_d;
      err_ecc     <= ecc_d;
      err_timeout <= to_d;
      err_trunc   <= tr_d;
      pld_valid   <= pv_d;
      pld_last    <= pl_d;
      pld_be      <= be_d;
      pld_data    <= data_d;
      vc_o        <= vc_d;
      dt_o        <= dt_d;
      wc_o        <= wc_d;
      busy        <= (state_d == PAYLOAD);
    end
  end

endmodule

// File: tb/tb_csi_pkt_ctrl.sv
// Scoreboard bench for csi_pkt_ctrl; ECC scenario follows CSI_PKT_ECC_CHECK_EN.
`timescale 1ns/1ps
module tb_csi_pkt_ctrl;

  typedef struct packed {
    logic        fs, fe, ls, le, rs, e_ecc, e_to, e_tr, busy, pv, pl;
    logic [3:0]  be;
    logic [31:0] data;
    logic [1:0]  vc;
    logic [5:0]  dt;
    logic [15:0] wc;
  } obs_t;

  typedef struct packed {
    logic        en, v, s;
    logic [31:0] d;
  } stim_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] merging_dat = '0;
  logic        merging_valid = 1'b0;
  logic        pkt_sof = 1'b0;
  logic        frame_start, frame_end, line_start, line_end;
  logic [1:0]  vc_o;
  logic [5:0]  dt_o;
  logic [15:0] wc_o;
  logic [31:0] pld_data;
  logic [3:0]  pld_be;
  logic        pld_valid, pld_last, lane_resync;
  logic        err_ecc, err_timeout, err_trunc, busy;

  int    n_chk  = 0;
  int    n_fail = 0;
  obs_t  m = '0;
  stim_t stim_q[$];
  obs_t  exp_q[$];

  csi_pkt_ctrl #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .merging_dat(merging_dat), .merging_valid(merging_valid), .pkt_sof(pkt_sof),
    .frame_start(frame_start), .frame_end(frame_end),
    .line_start(line_start), .line_end(line_end),
    .vc_o(vc_o), .dt_o(dt_o), .wc_o(wc_o),
    .pld_data(pld_data), .pld_be(pld_be), .pld_valid(pld_valid), .pld_last(pld_last),
    .lane_resync(lane_resync), .err_ecc(err_ecc), .err_timeout(err_timeout),
    .err_trunc(err_trunc), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample();
    obs_t o;
    o = '{fs: frame_start, fe: frame_end, ls: line_start, le: line_end, rs: lane_resync,
          e_ecc: err_ecc, e_to: err_timeout, e_tr: err_trunc, busy: busy,
          pv: pld_valid, pl: pld_last, be: pld_be, data: pld_data,
          vc: vc_o, dt: dt_o, wc: wc_o};
    return o;
  endfunction

  function automatic logic [5:0] ecc6(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return p;
  endfunction

  function automatic logic [31:0] hdr(input logic [1:0] vc, input logic [5:0] dt,
                                      input logic [15:0] wc);
    logic [23:0] h;
    h = {wc, vc, dt};
    return {2'b00, ecc6(h), h};
  endfunction

  // Expected outputs with all pulses cleared and held fields carried from the last cycle.
  function automatic obs_t quiet(input logic b);
    obs_t e;
    e = m;
    {e.fs, e.fe, e.ls, e.le, e.rs, e.e_ecc, e.e_to, e.e_tr, e.pv, e.pl} = '0;
    e.busy = b;
    return e;
  endfunction

  function automatic obs_t hdr_exp(input logic [1:0] vc, input logic [5:0] dt,
                                   input logic [15:0] wc, input logic b);
    obs_t e;
    e = quiet(b);
    e.vc = vc; e.dt = dt; e.wc = wc;
    return e;
  endfunction

  function automatic obs_t pld_exp(input logic [31:0] d, input logic [3:0] be,
                                   input logic last, input logic b);
    obs_t e;
    e = quiet(b);
    e.pv = 1'b1; e.data = d; e.be = be; e.pl = last;
    if (!b) e.rs = 1'b1;
    return e;
  endfunction

  task automatic add(input logic en, input logic v, input logic s, input logic [31:0] d,
                     input obs_t e);
    stim_t st;
    st = '{en: en, v: v, s: s, d: d};
    stim_q.push_back(st);
    exp_q.push_back(e);
    m = e;
  endtask

  task automatic test_reset();
    obs_t got;
    repeat (2) @(negedge clk);
    got = sample(); n_chk++;
    if (got !== obs_t'('0)) begin n_fail++; $display("FAIL reset_hold got=%h exp=0", got); end
    reset = 1'b0; enable = 1'b1;
    @(negedge clk);
    got = sample(); n_chk++;
    if (got !== obs_t'('0)) begin n_fail++; $display("FAIL reset_release got=%h exp=0", got); end
    m = '0;
  endtask

  task automatic test_short();
    obs_t e, got;
    stim_t s;
    add(1, 1, 0, 32'hDEADBEEF, quiet(0));
    e = hdr_exp(1, 6'h00, 16'h1234, 0); e.fs = 1; e.rs = 1; add(1, 1, 1, hdr(1, 6'h00, 16'h1234), e);
    e = hdr_exp(2, 6'h01, 16'h0001, 0); e.fe = 1; e.rs = 1; add(1, 1, 1, hdr(2, 6'h01, 16'h0001), e);
    e = hdr_exp(0, 6'h02, 16'h0005, 0); e.ls = 1; e.rs = 1; add(1, 1, 1, hdr(0, 6'h02, 16'h0005), e);
    e = hdr_exp(3, 6'h03, 16'h0006, 0); e.le = 1; e.rs = 1; add(1, 1, 1, hdr(3, 6'h03, 16'h0006), e);
    e = hdr_exp(0, 6'h08, 16'h0077, 0); e.rs = 1; add(1, 1, 1, hdr(0, 6'h08, 16'h0077), e);
    e = hdr_exp(1, 6'h0F, 16'hABCD, 0); e.rs = 1; add(1, 1, 1, hdr(1, 6'h0F, 16'hABCD), e);
    add(1, 0, 0, 32'h0, quiet(0));
    for (int k = 0; stim_q.size() > 0; k++) begin
      s = stim_q.pop_front(); {enable, merging_valid, pkt_sof, merging_dat} = s;
      @(negedge clk); e = exp_q.pop_front(); got = sample(); n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL short cyc%0d got=%h exp=%h", k, got, e); end
    end
  endtask

  task automatic test_long();
    obs_t e, got;
    stim_t s;
    add(1, 1, 1, hdr(0, 6'h2A, 16'd6), hdr_exp(0, 6'h2A, 16'd6, 1));
    add(1, 1, 0, 32'h11223344, pld_exp(32'h11223344, 4'hF, 0, 1));
    add(1, 1, 0, 32'h55667788, pld_exp(32'h55667788, 4'h3, 1, 0));
    add(1, 0, 0, 32'h0, quiet(0));
    add(1, 1, 1, hdr(2, 6'h10, 16'd3), hdr_exp(2, 6'h10, 16'd3, 1));
    add(1, 1, 0, 32'hA1A2A3A4, pld_exp(32'hA1A2A3A4, 4'h7, 1, 1));
    e = quiet(0); e.rs = 1; add(1, 1, 0, 32'hC0C0C0C0, e);
    add(1, 0, 0, 32'h0, quiet(0));
    for (int k = 0; stim_q.size() > 0; k++) begin
      s = stim_q.pop_front(); {enable, merging_valid, pkt_sof, merging_dat} = s;
      @(negedge clk); e = exp_q.pop_front(); got = sample(); n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL long cyc%0d got=%h exp=%h", k, got, e); end
    end
  endtask

  task automatic test_crc_only();
    obs_t e, got;
    stim_t s;
    add(1, 1, 1, hdr(1, 6'h24, 16'd4), hdr_exp(1, 6'h24, 16'd4, 1));
    add(1, 1, 0, 32'hCAFEF00D, pld_exp(32'hCAFEF00D, 4'hF, 1, 1));
    add(1, 0, 0, 32'h0, quiet(1));
    e = quiet(0); e.rs = 1; add(1, 1, 0, 32'h12345678, e);
    add(1, 1, 1, hdr(3, 6'h12, 16'd0), hdr_exp(3, 6'h12, 16'd0, 1));
    e = quiet(0); e.rs = 1; add(1, 1, 0, 32'h87654321, e);
    add(1, 0, 0, 32'h0, quiet(0));
    for (int k = 0; stim_q.size() > 0; k++) begin
      s = stim_q.pop_front(); {enable, merging_valid, pkt_sof, merging_dat} = s;
      @(negedge clk); e = exp_q.pop_front(); got = sample(); n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL crc_only cyc%0d got=%h exp=%h", k, got, e); end
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, got;
    stim_t s;
    add(1, 1, 1, hdr(2, 6'h2B, 16'd5), hdr_exp(2, 6'h2B, 16'd5, 1));
    add(1, 1, 0, 32'h01020304, pld_exp(32'h01020304, 4'hF, 0, 1));
    add(1, 1, 0, 32'h05060708, pld_exp(32'h05060708, 4'h1, 1, 0));
    e = hdr_exp(0, 6'h00, 16'h0042, 0); e.fs = 1; e.rs = 1; add(1, 1, 1, hdr(0, 6'h00, 16'h0042), e);
    add(1, 1, 1, hdr(1, 6'h1E, 16'd0), hdr_exp(1, 6'h1E, 16'd0, 1));
    e = quiet(0); e.rs = 1; add(1, 1, 0, 32'h99999999, e);
    e = hdr_exp(1, 6'h03, 16'h0010, 0); e.le = 1; e.rs = 1; add(1, 1, 1, hdr(1, 6'h03, 16'h0010), e);
    add(1, 0, 0, 32'h0, quiet(0));
    for (int k = 0; stim_q.size() > 0; k++) begin
      s = stim_q.pop_front(); {enable, merging_valid, pkt_sof, merging_dat} = s;
      @(negedge clk); e = exp_q.pop_front(); got = sample(); n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL back_to_back cyc%0d got=%h exp=%h", k, got, e); end
    end
  endtask

  task automatic test_enable();
    obs_t e, got;
    stim_t s;
    add(1, 1, 1, hdr(0, 6'h2A, 16'd40), hdr_exp(0, 6'h2A, 16'd40, 1));
    add(1, 1, 0, 32'hAAAA5555, pld_exp(32'hAAAA5555, 4'hF, 0, 1));
    add(0, 1, 0, 32'hBBBB6666, quiet(0));
    add(0, 1, 1, hdr(1, 6'h00, 16'd1), quiet(0));
    add(1, 1, 0, 32'hCCCC7777, quiet(0));
    add(1, 0, 0, 32'h0, quiet(0));
    for (int k = 0; stim_q.size() > 0; k++) begin
      s = stim_q.pop_front(); {enable, merging_valid, pkt_sof, merging_dat} = s;
      @(negedge clk); e = exp_q.pop_front(); got = sample(); n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL enable cyc%0d got=%h exp=%h", k, got, e); end
    end
  endtask

  task automatic test_timeout();
    obs_t e, got;
    stim_t s;
    add(1, 1, 1, hdr(1, 6'h2A, 16'd100), hdr_exp(1, 6'h2A, 16'd100, 1));
    add(1, 1, 0, 32'h00000001, pld_exp(32'h00000001, 4'hF, 0, 1));
    add(1, 1, 0, 32'h00000002, pld_exp(32'h00000002, 4'hF, 0, 1));
    repeat (12) add(1, 0, 0, 32'h0, quiet(1));
    add(1, 1, 0, 32'h00000003, pld_exp(32'h00000003, 4'hF, 0, 1));
    repeat (15) add(1, 0, 0, 32'h0, quiet(1));
    e = quiet(0); e.e_to = 1; e.rs = 1; add(1, 0, 0, 32'h0, e);
    repeat (2) add(1, 0, 0, 32'h0, quiet(0));
    for (int k = 0; stim_q.size() > 0; k++) begin
      s = stim_q.pop_front(); {enable, merging_valid, pkt_sof, merging_dat} = s;
      @(negedge clk); e = exp_q.pop_front(); got = sample(); n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL timeout cyc%0d got=%h exp=%h", k, got, e); end
    end
  endtask

  task automatic test_trunc();
    obs_t e, got;
    stim_t s;
    add(1, 1, 1, hdr(1, 6'h2A, 16'd20), hdr_exp(1, 6'h2A, 16'd20, 1));
    add(1, 1, 0, 32'hDEAD0001, pld_exp(32'hDEAD0001, 4'hF, 0, 1));
    e = hdr_exp(2, 6'h03, 16'd9, 0); e.e_tr = 1; e.le = 1; e.rs = 1;
    add(1, 1, 1, hdr(2, 6'h03, 16'd9), e);
    add(1, 1, 0, 32'hDEAD0002, quiet(0));
    add(1, 1, 1, hdr(0, 6'h2A, 16'd20), hdr_exp(0, 6'h2A, 16'd20, 1));
    add(1, 1, 0, 32'hDEAD0003, pld_exp(32'hDEAD0003, 4'hF, 0, 1));
    e = hdr_exp(3, 6'h2C, 16'd0, 1); e.e_tr = 1; add(1, 1, 1, hdr(3, 6'h2C, 16'd0), e);
    e = quiet(0); e.rs = 1; add(1, 1, 0, 32'hDEAD0004, e);
    add(1, 0, 0, 32'h0, quiet(0));
    for (int k = 0; stim_q.size() > 0; k++) begin
      s = stim_q.pop_front(); {enable, merging_valid, pkt_sof, merging_dat} = s;
      @(negedge clk); e = exp_q.pop_front(); got = sample(); n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL trunc cyc%0d got=%h exp=%h", k, got, e); end
    end
  endtask

  task automatic test_ecc();
    obs_t e, got;
    stim_t s;
    add(1, 1, 1, hdr(1, 6'h2A, 16'd0), hdr_exp(1, 6'h2A, 16'd0, 1));
    e = quiet(0); e.rs = 1; add(1, 1, 0, 32'h0BADF00D, e);
`ifdef CSI_PKT_ECC_CHECK_EN
    e = quiet(0); e.e_ecc = 1; e.rs = 1; add(1, 1, 1, hdr(2, 6'h2B, 16'd8) ^ 32'h01000000, e);
    add(1, 1, 0, 32'h11111111, quiet(0));
    add(1, 1, 0, 32'h22222222, quiet(0));
    e = quiet(0); e.e_ecc = 1; e.rs = 1; add(1, 1, 1, hdr(0, 6'h00, 16'd1) ^ 32'h01000000, e);
`else
    add(1, 1, 1, hdr(2, 6'h2B, 16'd0) ^ 32'h01000000, hdr_exp(2, 6'h2B, 16'd0, 1));
    e = quiet(0); e.rs = 1; add(1, 1, 0, 32'h11111111, e);
`endif
    add(1, 0, 0, 32'h0, quiet(0));
    for (int k = 0; stim_q.size() > 0; k++) begin
      s = stim_q.pop_front(); {enable, merging_valid, pkt_sof, merging_dat} = s;
      @(negedge clk); e = exp_q.pop_front(); got = sample(); n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL ecc cyc%0d got=%h exp=%h", k, got, e); end
    end
  endtask

  task automatic test_reset_mid();
    obs_t e, got;
    stim_t s;
    add(1, 1, 1, hdr(3, 6'h2A, 16'd64), hdr_exp(3, 6'h2A, 16'd64, 1));
    add(1, 1, 0, 32'h5A5A5A5A, pld_exp(32'h5A5A5A5A, 4'hF, 0, 1));
    for (int k = 0; stim_q.size() > 0; k++) begin
      s = stim_q.pop_front(); {enable, merging_valid, pkt_sof, merging_dat} = s;
      @(negedge clk); e = exp_q.pop_front(); got = sample(); n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL reset_mid cyc%0d got=%h exp=%h", k, got, e); end
    end
    merging_valid = 1'b1; merging_dat = 32'h6B6B6B6B;
    reset = 1'b1;
    #1;
    got = sample(); n_chk++;
    if (got !== obs_t'('0)) begin n_fail++; $display("FAIL reset_mid_async got=%h exp=0", got); end
    @(negedge clk);
    merging_valid = 1'b0;
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      got = sample(); n_chk++;
      if (got !== obs_t'('0)) begin n_fail++; $display("FAIL reset_mid_after got=%h exp=0", got); end
    end
    m = '0;
  endtask

  initial begin
    test_reset();
    test_short();
    test_long();
    test_crc_only();
    test_back_to_back();
    test_enable();
    test_timeout();
    test_trunc();
    test_ecc();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/csi_pkt_ctrl.md
# csi_pkt_ctrl

CSI-2 packet controller that sits directly after the lane-merging stage on the MIPI receive path. It consumes 32-bit merged words with their start-of-packet flag and parses the packet header. It sequences long-packet payload and CRC by byte count, and emits short-packet sync events and a byte-enabled payload stream. It also tells the lane aligner when to re-hunt for sync, at packet end or on error.

## Interface
Parameters:
- TIMEOUT, 64: idle cycles without merging_valid inside a long packet before abort; must be ≥ 8.

Ports:
- clk  in  1  clock, single domain
- reset  in  1  asynchronous, active-high reset
- enable  in  1  controller enable; low forces IDLE and ignores input
- merging_dat  in  32  merged word, first received byte in [7:0]
- merging_valid  in  1  merging_dat valid this cycle
- pkt_sof  in  1  current valid word is a packet header
- frame_start / frame_end / line_start / line_end  out  1 each  one-cycle short-packet event pulses
- vc_o  out  2  virtual channel of the last accepted header
- dt_o  out  6  data type of the last accepted header
- wc_o  out  16  word count (or short-packet data field) of the last accepted header
- pld_data  out  32  payload word
- pld_be  out  4  byte enables for pld_data, bit n covers [8n+7:8n]
- pld_valid  out  1  payload word valid
- pld_last  out  1  last payload word of the packet, qualified by pld_valid
- lane_resync  out  1  one-cycle pulse requesting the aligner to re-hunt sync
- err_ecc / err_timeout / err_trunc  out  1 each  one-cycle error pulses
- busy  out  1  high while in PAYLOAD

## Operation
- Header fields: DI = dat[7:0], where VC = DI[7:6] and DT = DI[5:0]; WC = dat[23:8], little-endian; ECC = dat[31:24].
- IDLE: a word with merging_valid & pkt_sof & enable is a header. Words without pkt_sof are discarded. The header latches vc_o, dt_o and wc_o.
- Short packet (DT ≤ 0x0F):
  - DT 0x00/0x01/0x02/0x03 pulse frame_start/frame_end/line_start/line_end respectively.
  - Other short DTs produce no event.
  - Always pulse lane_resync; remain in IDLE.
- Long packet (DT ≥ 0x10): load rem = WC + 2 (17-bit) and go to PAYLOAD.
- PAYLOAD, each valid word:
  - pay = rem − 2 (signed), the payload bytes remaining.
  - If pay > 0: pld_valid = 1 and pld_be = lowest min(pay, 4) bits set. pld_last = 1 when pay ≤ 4.
  - Then rem = rem − 4.
  - When rem ≤ 4 before the decrement, this is the final word. Pulse lane_resync and go to IDLE.
  - CRC bytes are never forwarded and never checked.
- WC = 0: no pld_valid at all; one CRC word, then lane_resync.
- Timeout: an idle counter resets on every merging_valid in PAYLOAD. If it reaches TIMEOUT: pulse err_timeout and lane_resync, go to IDLE, and emit no pld_last.
- pkt_sof on a valid word in PAYLOAD: pulse err_trunc. The current packet ends without pld_last, and the word is processed as a new header in the same cycle.
- enable falling in PAYLOAD: go to IDLE immediately with no pulses.

## Timing
- Every output is registered. Each output appears exactly 1 cycle after the input word that causes it.
- Reset value:
  - All pulses, pld_valid, pld_last and busy are 0.
  - pld_data, pld_be, vc_o, dt_o and wc_o are 0.
  - State is IDLE and the counters are 0.
- Reset mid-packet aborts silently: no lane_resync and no error pulse.
- pld_data is the registered merging_dat; it is held when pld_valid = 0.
- Back-to-back packets: a header is accepted in the cycle after the final word of the previous packet.
- busy rises the cycle after a long header and falls the cycle after the final word.

## Configuration
- CSI_PKT_ECC_CHECK_EN defined:
  - Compute the 6-bit CSI-2 header ECC over dat[23:0] and compare it with dat[29:24].
  - On mismatch: pulse err_ecc and lane_resync, raise no event, do not enter PAYLOAD, and do not update vc_o, dt_o or wc_o.
  - Detect only; no correction.
- Not defined: the ECC byte is ignored and err_ecc is tied to 0.

## Structure
- Package csi_pkt_pkg holds:
  - DT constants DT_FS = 0x00, DT_FE = 0x01, DT_LS = 0x02, DT_LE = 0x03, DT_SHORT_MAX = 0x0F.
  - State type {IDLE, PAYLOAD}.
  - Header field offset constants.
- One sub-module, csi_ecc_calc: combinational, 24-bit in, 6-bit out. It is instantiated only under CSI_PKT_ECC_CHECK_EN.

## Test plan
- Short packet: header 0x??000000 (DT 0x00) with pkt_sof → frame_start = 1 for one cycle, lane_resync = 1 in the same cycle, busy stays 0.
- Long packet, DT 0x2A, WC = 6:
  - Two words → word 1: pld_be = 0xF, pld_last = 0.
  - Word 2: pld_be = 0x3, pld_last = 1, lane_resync = 1.
- Long packet, WC = 4: payload word pld_be = 0xF with pld_last = 1, then the CRC word gives pld_valid = 0 and lane_resync = 1. With WC = 0: a single CRC word and no pld_valid.
- Timeout: TIMEOUT = 16, WC = 100, stop merging_valid after 3 words → err_timeout and lane_resync 16 cycles later, busy falls, no pld_last.
- Truncation: pkt_sof on a line_end header mid-PAYLOAD → err_trunc = 1 and line_end = 1 in the same cycle, state IDLE.
- With CSI_PKT_ECC_CHECK_EN: a header with ECC bit 0 flipped → err_ecc = 1, lane_resync = 1, dt_o unchanged, and the following words are ignored.
